// File: rtl/divider_if.sv
// rtl/divider_if.sv - request/result bundle between the divider and its user
interface divider_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         ready;
  logic         done;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, ready, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, ready, done, div_by_zero
  );
endinterface

// File: rtl/divider.sv
// rtl/divider.sv - unsigned restoring shift-subtract divider, one quotient bit per clock
// Optional DIVIDER_DBZ_EN: divisor 0 short-circuits to DONE in one clock and raises div_by_zero.
module divider #(
  parameter int N = 8
) (
  input logic       clk_i,
  input logic       rst_i,
  divider_if.slave  bus
);
  localparam int CW = $clog2(N + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  m_q, m_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dbz_q, dbz_d;
  logic [N:0]    shift_a;
  logic [N:0]    trial;

  // A never exceeds the divisor after a restore, so its borrow bit lives only in trial[N].
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    shift_a = {a_q, q_q[N-1]};
    trial   = shift_a - {1'b0, m_q};
    case (state_q)
      S_RUN: begin
        if (!trial[N]) begin
          a_d = trial[N-1:0];
          q_d = {q_q[N-2:0], 1'b1};
        end else begin
          a_d = shift_a[N-1:0];
          q_d = {q_q[N-2:0], 1'b0};
        end
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          state_d = S_DONE;
          quot_d  = q_d;
          rem_d   = a_d;
        end
      end
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          a_d     = '0;
          q_d     = bus.dividend;
          m_d     = bus.divisor;
          count_d = CW'(N);
          dbz_d   = 1'b0;
          state_d = S_RUN;
`ifdef DIVIDER_DBZ_EN
          if (bus.divisor == '0) begin
            state_d = S_DONE;
            count_d = '0;
            quot_d  = '1;
            rem_d   = bus.dividend;
            dbz_d   = 1'b1;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      count_q <= '0;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.ready       = (state_q != S_RUN);
  assign bus.done        = (state_q == S_DONE);
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
endmodule

// File: doc/divider.md
# divider

Sequential unsigned restoring shift-subtract divider: the inverse of the shift-add multiplier datapath. It sits beside the multiplier under the same slow clock and produces an n-bit quotient and n-bit remainder from an n-bit dividend and n-bit divisor. It computes one quotient bit per clock and reports completion with a ready/done handshake.

## Interface
- n, 8, operand width in bits (n ≥ 2)

- clock  input  1  system (slow) clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while ready=1
- dividend  input  n  unsigned dividend, sampled on accepted start
- divisor  input  n  unsigned divisor, sampled on accepted start
- quotient  output  n  result quotient; holds until next accepted start
- remainder  output  n  result remainder; holds until next accepted start
- ready  output  1  1 = idle, able to accept start
- done  output  1  one-cycle pulse when results become valid
- div_by_zero  output  1  1 = last accepted operation had divisor 0 (see Configuration)

## Operation
- State machine: IDLE, RUN, DONE.
- IDLE: ready=1. When start=1 at an edge: load A(n+1 bits)=0, Q=dividend, M=divisor, count=n; go to RUN. div_by_zero cleared on accept.
- RUN: ready=0. Each cycle: {A,Q} shifted left 1 (A takes Q msb); T = A − {0,M} (n+1 bits). If T msb = 0: A=T, Q[0]=1; else A unchanged (restore), Q[0]=0. count decrements; on the iteration where count=1, go to DONE.
- DONE: one cycle; done=1, ready=1, quotient=Q, remainder=A[n-1:0]; a start in DONE is accepted exactly as in IDLE. Next state IDLE (or RUN if start accepted).
- start while ready=0 is ignored; no queuing.
- Operands are captured at accept; later changes to dividend/divisor have no effect on the running operation.
- All arithmetic unsigned; A needs n+1 bits so the trial subtract borrow is the sign bit. Remainder is always < divisor when divisor ≠ 0.
- Divisor 0 result (both configurations): quotient = all ones, remainder = dividend.

## Timing
- Reset values: quotient=0, remainder=0, ready=1, done=0, div_by_zero=0, state IDLE, count=0.
- Reset mid-operation: aborts at that edge; returns to reset values, no done pulse.
- Start accepted at edge k → RUN cycles after edges k..k+n−1 → done=1 and results valid after edge k+n (latency n clocks). ready returns to 1 in the same cycle as done.
- quotient/remainder update only on the edge entering DONE; stable otherwise.
- Back-to-back: start held high through DONE starts the next operation at edge k+n+1; throughput one result per n+1 clocks.
- reset and start high at the same edge: reset wins.

## Configuration
- DIVIDER_DBZ_EN defined: divisor=0 at accept skips RUN; next edge enters DONE with quotient=all ones, remainder=dividend, div_by_zero=1, done=1 (latency 1). div_by_zero holds until next accepted start or reset.
- Not defined: no special case; divisor 0 runs the full n iterations, yielding the same quotient/remainder naturally; div_by_zero tied to 0.

## Test plan
- n=8, dividend=100, divisor=7, start one cycle → done exactly 8 clocks later, quotient=14, remainder=2, ready=1.
- dividend=5, divisor=10 → quotient=0, remainder=5; dividend=255, divisor=1 → quotient=255, remainder=0; dividend=255, divisor=255 → 1, 0.
- dividend=77, divisor=0 → with DIVIDER_DBZ_EN: done after 1 clock, quotient=255, remainder=77, div_by_zero=1; without: done after 8 clocks, same values, div_by_zero=0.
- Start 200/9, then pulse start with 50/5 and change operands 3 cycles in → second start ignored, result 22 r 2 after 8 clocks.
- Start 200/9, assert reset 4 cycles in → next cycle quotient=0, remainder=0, ready=1, no done pulse; new start 16/16 gives 1 r 0.
- start held high continuously with 100/7 → done pulses every 9 clocks, each with 14 r 2.
